// File: rtl/ball_move.sv
// Breakout ball motion engine: serve from paddle, per-tick flight with wall/paddle/brick reflection,
// loss handling with respawn delay, lives and sticky game over. Outputs registered, 1 clk after tick.
module ball_move #(
   parameter int SCREEN_W      = 320,
   parameter int SCREEN_H      = 240,
   parameter int BALL_SIZE     = 4,
   parameter int PAD_W         = 80,
   parameter int LIVES         = 3,
   parameter int RESPAWN_TICKS = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick,
   input  logic       launch_n,
   input  logic [9:0] padx,
   input  logic [9:0] pady,
   input  logic       padcol,
   input  logic [2:0] padang,
   input  logic       brickcol,
   input  logic       brickvert,
   output logic [9:0] ballx,
   output logic [9:0] bally,
   output logic [1:0] lives,
   output logic       ball_lost,
   output logic       game_over
);

   typedef enum logic [1:0] {IDLE, FLY, LOST, GAMEOVER} state_t;

   localparam int CW = $clog2(RESPAWN_TICKS + 1);
   localparam logic [9:0]        REST_DX  = 10'(PAD_W / 2 - BALL_SIZE / 2);
   localparam logic [9:0]        RST_X    = 10'(100 + PAD_W / 2 - BALL_SIZE / 2);
   localparam logic [9:0]        RST_Y    = 10'(200 - 1);
   localparam logic signed [10:0] X_MAX   = 11'(SCREEN_W - BALL_SIZE);
   localparam logic [9:0]        Y_LOSS   = 10'(SCREEN_H - 1);
   localparam logic [CW-1:0]     CNT_LAST = CW'(RESPAWN_TICKS - 1);

   state_t            state;
   logic signed [2:0] dx;
   logic signed [1:0] dy;
   logic [CW-1:0]     cnt;

   logic signed [2:0]  vdx, fdx;
   logic signed [1:0]  vdy, fdy;
   logic signed [10:0] nx, ny;
   logic [9:0]         fx, fy;
   logic               loss;

   // Flight step: paddle beats brick, then move with the updated velocity, then clamp at walls.
   always_comb begin
      vdx = dx;
      vdy = dy;
      if (padcol && dy == 2'sd1) begin
         vdy = -2'sd1;
         case (padang)
            3'd0:    vdx = -3'sd2;
            3'd1:    vdx = -3'sd1;
            3'd2:    vdx = 3'sd0;
            3'd3:    vdx = 3'sd1;
            3'd4:    vdx = 3'sd2;
            default: vdx = dx;
         endcase
      end else if (brickcol) begin
         if (brickvert) vdx = -dx;
         else           vdy = -dy;
      end

      nx = $signed({1'b0, ballx}) + $signed({{8{vdx[2]}}, vdx});
      ny = $signed({1'b0, bally}) + $signed({{9{vdy[1]}}, vdy});

      fx  = nx[9:0];
      fdx = vdx;
      if (nx < 0) begin
         fx  = 10'd0;
         fdx = -vdx;
      end else if (nx > X_MAX) begin
         fx  = X_MAX[9:0];
         fdx = -vdx;
      end

      fy  = ny[9:0];
      fdy = vdy;
      if (ny < 0) begin
         fy  = 10'd1;
         fdy = 2'sd1;
      end

      loss = (bally >= Y_LOSS) && (dy == 2'sd1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         dx        <= 3'sd0;
         dy        <= 2'sd0;
         cnt       <= '0;
         ballx     <= RST_X;
         bally     <= RST_Y;
         lives     <= 2'(LIVES);
         ball_lost <= 1'b0;
         game_over <= 1'b0;
      end else begin
         ball_lost <= 1'b0;
         if (tick) begin
            case (state)
               IDLE: begin
                  ballx <= padx + REST_DX;
                  bally <= pady - 10'd1;
                  if (!launch_n) begin
                     dx    <= 3'sd1;
                     dy    <= -2'sd1;
                     state <= FLY;
                  end
               end
               FLY: begin
                  if (loss) begin
                     state     <= LOST;
                     ball_lost <= 1'b1;
                     cnt       <= '0;
                     if (lives != 2'd0) lives <= lives - 2'd1;
                  end else begin
                     dx    <= fdx;
                     dy    <= fdy;
                     ballx <= fx;
                     bally <= fy;
                  end
               end
               LOST: begin
                  if (cnt == CNT_LAST) begin
                     dx  <= 3'sd0;
                     dy  <= 2'sd0;
                     cnt <= '0;
                     if (lives != 2'd0) begin
                        // re-serve with the ball already sitting on the paddle
                        state <= IDLE;
                        ballx <= padx + REST_DX;
                        bally <= pady - 10'd1;
                     end else begin
                        state     <= GAMEOVER;
                        game_over <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               GAMEOVER: begin
                  state <= GAMEOVER;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ball_move.sv
// Randomized bench for ball_move against a behavioural game model, plus directed serve/loss/reset scenarios.
module tb_ball_move;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic       launch_n = 1'b1;
   logic [9:0] padx = 10'd100;
   logic [9:0] pady = 10'd200;
   logic       padcol = 1'b0;
   logic [2:0] padang = 3'd0;
   logic       brickcol = 1'b0;
   logic       brickvert = 1'b0;
   logic [9:0] ballx, bally;
   logic [1:0] lives;
   logic       ball_lost, game_over;

   ball_move dut (
      .clk(clk), .rst(rst), .tick(tick), .launch_n(launch_n),
      .padx(padx), .pady(pady), .padcol(padcol), .padang(padang),
      .brickcol(brickcol), .brickvert(brickvert),
      .ballx(ballx), .bally(bally), .lives(lives),
      .ball_lost(ball_lost), .game_over(game_over)
   );

   always #5 clk = ~clk;

   localparam int M_IDLE = 0, M_FLY = 1, M_LOST = 2, M_OVER = 3;

   int n_vec = 0;
   int n_err = 0;
   int m_mode, m_x, m_y, m_vx, m_vy, m_lives, m_go, m_pulse, m_wait;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_mode = M_IDLE; m_x = 138; m_y = 199; m_vx = 0; m_vy = 0;
      m_lives = 3; m_go = 0; m_pulse = 0; m_wait = 0;
   endtask

   task automatic model_step();
      int nx, ny;
      m_pulse = 0;
      case (m_mode)
         M_IDLE: begin
            m_x = int'(padx) + 38;
            m_y = int'(pady) - 1;
            if (!launch_n) begin m_vx = 1; m_vy = -1; m_mode = M_FLY; end
         end
         M_FLY: begin
            if (m_y >= 239 && m_vy == 1) begin
               m_mode = M_LOST; m_pulse = 1; m_wait = 0;
               if (m_lives > 0) m_lives = m_lives - 1;
            end else begin
               if (padcol && m_vy == 1) begin
                  m_vy = -1;
                  if (padang <= 4) m_vx = int'(padang) - 2;
               end else if (brickcol) begin
                  if (brickvert) m_vx = -m_vx;
                  else           m_vy = -m_vy;
               end
               nx = m_x + m_vx;
               ny = m_y + m_vy;
               if (nx < 0)        begin m_x = 0;   m_vx = -m_vx; end
               else if (nx > 316) begin m_x = 316; m_vx = -m_vx; end
               else                m_x = nx;
               if (ny < 0) begin m_y = 1; m_vy = 1; end
               else        m_y = ny;
            end
         end
         M_LOST: begin
            m_wait++;
            if (m_wait == 60) begin
               m_vx = 0; m_vy = 0;
               if (m_lives > 0) begin
                  m_mode = M_IDLE;
                  m_x = int'(padx) + 38;
                  m_y = int'(pady) - 1;
               end else begin
                  m_mode = M_OVER; m_go = 1;
               end
            end
         end
         default: ;
      endcase
   endtask

   // One clk cycle: drive at negedge, model follows the posedge, outputs compared at the next negedge.
   task automatic do_cycle(input logic t);
      tick = t;
      @(posedge clk);
      if (rst)    model_reset();
      else if (t) model_step();
      else        m_pulse = 0;
      @(negedge clk);
      tick = 1'b0;
      chk("ballx", 32'(ballx), 32'(m_x));
      chk("bally", 32'(bally), 32'(m_y));
      chk("lives", 32'(lives), 32'(m_lives));
      chk("game_over", 32'(game_over), 32'(m_go));
      chk("ball_lost", 32'(ball_lost), 32'(m_pulse));
   endtask

   task automatic serve();
      launch_n = 1'b0;
      do_cycle(1'b1);
      launch_n = 1'b1;
   endtask

   task automatic fly_until_loss();
      logic seen;
      seen = 1'b0;
      padcol = 1'b0; brickcol = 1'b0;
      for (int i = 0; i < 1200 && !seen; i++) begin
         do_cycle(1'b1);
         if (ball_lost === 1'b1) seen = 1'b1;
         do_cycle(1'b0);
      end
      chk("loss_seen", 32'(seen), 32'd1);
   endtask

   initial begin
      int sx, sy;
      model_reset();
      repeat (3) do_cycle(1'b0);
      rst = 1'b0;
      do_cycle(1'b0);
      chk("reset_x", 32'(ballx), 32'd138);
      chk("reset_y", 32'(bally), 32'd199);
      chk("reset_lives", 32'(lives), 32'd3);
      chk("reset_go", 32'(game_over), 32'd0);

      padx = 10'd120;
      do_cycle(1'b1);
      chk("follow_x", 32'(ballx), 32'd158);

      padx = 10'd100; pady = 10'd200;
      serve();
      do_cycle(1'b0);
      repeat (3) do_cycle(1'b1);
      chk("launch_x", 32'(ballx), 32'd141);
      chk("launch_y", 32'(bally), 32'd196);

      fly_until_loss();
      chk("lives_after_loss", 32'(lives), 32'd2);
      repeat (61) do_cycle(1'b1);
      chk("respawn_x", 32'(ballx), 32'd138);
      chk("respawn_y", 32'(bally), 32'd199);

      // asynchronous reset between clock edges mid-flight
      serve();
      repeat (10) do_cycle(1'b1);
      #2 rst = 1'b1;
      #1;
      chk("async_x", 32'(ballx), 32'd138);
      chk("async_y", 32'(bally), 32'd199);
      chk("async_lives", 32'(lives), 32'd3);
      do_cycle(1'b1);
      rst = 1'b0;

      for (int k = 0; k < 3; k++) begin
         serve();
         fly_until_loss();
         repeat (60) do_cycle(1'b1);
      end
      chk("go_set", 32'(game_over), 32'd1);
      chk("go_lives", 32'(lives), 32'd0);
      sx = m_x; sy = m_y;
      launch_n = 1'b0; padcol = 1'b1; brickcol = 1'b1; padx = 10'd7;
      repeat (5) do_cycle(1'b1);
      chk("freeze_x", 32'(ballx), 32'(sx));
      chk("freeze_y", 32'(bally), 32'(sy));
      launch_n = 1'b1; padcol = 1'b0; brickcol = 1'b0;

      rst = 1'b1;
      do_cycle(1'b0);
      rst = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         padx      = 10'($urandom_range(0, 240));
         pady      = 10'($urandom_range(100, 230));
         launch_n  = ($urandom_range(0, 5) != 0);
         padcol    = ($urandom_range(0, 150) == 0);
         padang    = 3'($urandom_range(0, 7));
         brickcol  = ($urandom_range(0, 30) == 0);
         brickvert = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 80) == 0) begin
            padcol = 1'b1; brickcol = 1'b1; brickvert = 1'b1;
         end
         rst = (m_mode == M_OVER) && ($urandom_range(0, 20) == 0);
         do_cycle(1'b1);
         rst = 1'b0;
         repeat ($urandom_range(0, 2)) do_cycle(1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ball_move.md
Name: ball_move

Overview:
- Ball motion engine for the Breakout datapath. It is the consumer of the paddle block's collision outputs (padcol, padang) and the producer of the ballx/bally coordinates that the paddle block and the brick logic sample.
- Holds the ball on the paddle until launch, then advances it one step per frame tick.
- Reflects the ball off walls, the paddle and bricks, and handles ball loss, lives and game over.

Parameters:
- SCREEN_W, 320, playfield width in pixels
- SCREEN_H, 240, playfield height in pixels
- BALL_SIZE, 4, ball edge length in pixels
- PAD_W, 80, paddle width, used to centre the resting ball
- LIVES, 3, lives at reset (max 3)
- RESPAWN_TICKS, 60, frame ticks spent in LOST before re-serve

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- tick  in  1  one-clk frame-rate enable pulse; all motion updates happen only on clk edges where tick=1
- launch_n  in  1  active-low serve button, level-sampled on tick
- padx  in  10  paddle left x
- pady  in  10  paddle top y
- padcol  in  1  paddle collision flag
- padang  in  3  paddle hit zone, 0..4 from left to right
- brickcol  in  1  brick collision flag
- brickvert  in  1  1 = side face of brick hit, 0 = top/bottom face hit
- ballx  out  10  ball left x
- bally  out  10  ball y
- lives  out  2  remaining lives
- ball_lost  out  1  one-clk pulse on each ball loss
- game_over  out  1  sticky until rst

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-flight):
  - state=IDLE, dx=0, dy=0, lives=LIVES, ball_lost=0, game_over=0.
  - ballx=138, bally=199 (resting position for padx=100, pady=200).
- Velocity registers:
  - dx is signed 3-bit, range -2..+2.
  - dy is signed 2-bit, always ±1 while in flight; unit dy is required by the paddle's exact bally==pady test.
- States:
  - IDLE:
    - On every tick: ballx = padx + PAD_W/2 - BALL_SIZE/2, bally = pady - 1.
    - If launch_n=0 on a tick: dx=+1, dy=-1, go to FLY. Position is still the resting value on that tick.
  - FLY: on each tick, evaluated in this priority order:
    1. Loss: bally >= SCREEN_H-1 with dy=+1 → LOST; ball_lost=1 for exactly one clk; lives-1, saturating at 0; position holds.
    2. Paddle: padcol=1 with dy=+1 → dy=-1 and dx from padang: 0→-2, 1→-1, 2→0, 3→+1, 4→+2, 5..7→dx unchanged. padcol while dy=-1 is ignored (no double bounce).
    3. Brick (only if the paddle rule did not fire): brickcol=1 → negate dx if brickvert=1, else negate dy. When padcol and brickcol are both valid on the same tick, the paddle wins and brickcol is dropped.
    4. Move using the updated dx/dy, computed 11-bit signed: nx = ballx + dx, ny = bally + dy.
    5. Side walls: if nx < 0 → ballx=0, dx=-dx. If nx > SCREEN_W-BALL_SIZE (316) → ballx=316, dx=-dx. Otherwise ballx=nx.
    6. Top wall: if ny < 0 → bally=1, dy=+1. Otherwise bally=ny.
  - LOST:
    - A counter counts ticks. After RESPAWN_TICKS ticks: go to IDLE if lives>0, else go to GAMEOVER with game_over=1.
    - dx=dy=0 on exit.
  - GAMEOVER:
    - All outputs frozen; launch_n, padcol and brickcol are ignored. Only rst exits this state.
- Timing:
  - Between ticks every register holds its value.
  - Output latency is 1 clk from the tick edge; outputs are registered, with no combinational path from inputs to outputs.
  - ball_lost is asserted only in the clk cycle immediately after the tick edge that detects the loss.

Test Plan:
1. Reset and follow: assert rst mid-simulation, then release → ballx=138, bally=199, lives=3, game_over=0. Set padx=120, then one tick in IDLE → ballx=158.
2. Launch: padx=100, pady=200, launch_n=0 on a tick, then 3 further ticks → state FLY, ballx=141, bally=196.
3. Walls:
   - ballx=1, dx=-2, tick → ballx=0, dx=+2; next tick → ballx=2.
   - bally=0, dy=-1, tick → bally=1, dy=+1.
   - ballx=315, dx=+2 → ballx=316, dx=-2.
4. Paddle and brick:
   - dy=+1, padcol=1, padang=0 → dy=-1, dx=-2.
   - padang=6 → dx unchanged.
   - padcol with dy=-1 → no change.
   - padcol and brickcol on the same tick with brickvert=1 → dx set from padang, not negated.
5. Loss path:
   - bally=239, dy=+1, tick → ball_lost high for exactly 1 clk, lives=2.
   - After 60 ticks → IDLE at the resting position.
   - Third loss → after 60 ticks game_over=1; launch_n=0 is ignored and ballx/bally stay constant.
6. Asynchronous rst pulsed mid-FLY between clk edges → outputs take their reset values immediately, before the next clk edge.
